tone_freq_meter: RTL and testbench

//  Measures the 8-bit sawtooth produced by the phase-accumulator tone generator and recovers its
//  16-bit frequency word {mant[11:0], exp[3:0]}, where increment = mant << min(exp,12).

---
 rtl/tone_freq_meter_pkg.sv | 29 ++
 rtl/tone_freq_normaliser.sv | 40 ++++
 rtl/tone_freq_meter.sv | 108 ++++++++++
 tb/tb_tone_freq_meter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tone_freq_meter_pkg.sv
// Shared definitions for the tone frequency meter and the tone generator it measures.
package tone_freq_meter_pkg;

    localparam int ACC_W  = 24;
    localparam int MANT_W = 12;
    localparam int EXP_W  = 4;
    localparam logic [EXP_W-1:0] EXP_MAX = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        ENCODE = 2'd2,
        DONE   = 2'd3
    } meter_state_t;

    // Frequency word layout: {mant[11:0], exp[3:0]}.
    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
    } freq_word_t;

    // Increment encoded by a frequency word; exponents above EXP_MAX clamp to EXP_MAX.
    function automatic logic [ACC_W-1:0] word_to_incr(input freq_word_t w);
        logic [EXP_W-1:0] sh;
        sh = (w.exp > EXP_MAX) ? EXP_MAX : w.exp;
        return ACC_W'(w.mant) << sh;
    endfunction

endpackage

// File: rtl/tone_freq_normaliser.sv
// Iterative shift-right normaliser: turns a 24-bit increment estimate into the
// smallest-exponent {mant, exp} pair, one shift per enabled cycle.
module tone_freq_normaliser
    import tone_freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ACC_W-1:0] load_val,
    input  logic             step,
    output logic             done,
    output freq_word_t       word
);

    logic [ACC_W-1:0] val;
    logic [EXP_W-1:0] exp;

    // Load a fresh estimate, or shift it right until it fits the mantissa field.
    always_ff @(posedge clk) begin
        if (reset) begin
            val <= '0;
            exp <= '0;
        end else if (load) begin
            val <= load_val;
            exp <= '0;
        end else if (step && !done) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            val <= val >> 1;
            exp <= exp + 1'b1;
        end
    end

    // Normalised once the upper bits are clear; the low bits then form the mantissa.
    always_comb begin
        done      = (val[ACC_W-1:MANT_W] == '0);
        word.mant = val[MANT_W-1:0];
        word.exp  = exp;
    end

endmodule

// File: rtl/tone_freq_meter.sv
// Tone frequency meter: counts sawtooth wraps over a 2**GATE_LOG2 cycle gate,
// scales the count to a 24-bit increment and normalises it to a frequency word.
module tone_freq_meter
    import tone_freq_meter_pkg::*;
#(
    parameter int GATE_LOG2 = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sample_in,
    input  logic        start,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] freq_word,
    output logic        overflow
);

    meter_state_t state;
    meter_state_t next_state;

    logic [GATE_LOG2-1:0] gate_cnt;
    logic [GATE_LOG2-1:0] wrap_cnt;
    logic [GATE_LOG2-1:0] wrap_cnt_next;
    logic                 prev_msb;
    logic                 wrap;
    logic                 wrap_sat;
    logic                 accept;
    logic                 gate_end;

    logic                 norm_load;
    logic                 norm_step;
    logic                 norm_done;
    logic [ACC_W-1:0]     norm_val;
    freq_word_t           norm_word;

    // Wrap detection, saturating wrap count and gate-end scaling.
    always_comb begin
        accept        = start && ((state == IDLE) || (state == DONE));
        wrap          = prev_msb & ~sample_in[7];
        wrap_sat      = &wrap_cnt;
        wrap_cnt_next = (wrap && !wrap_sat) ? wrap_cnt + 1'b1 : wrap_cnt;
        gate_end      = (state == GATE) && (&gate_cnt);
        norm_val      = ACC_W'(wrap_cnt_next) << (ACC_W - GATE_LOG2);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)    next_state = GATE;
            GATE:    if (gate_end)  next_state = ENCODE;
            ENCODE:  if (norm_done) next_state = DONE;
            DONE:    if (accept)    next_state = GATE;
            default:                next_state = IDLE;
        endcase
    end

    // Moore outputs and normaliser control.
    always_comb begin
        busy         = (state == GATE) || (state == ENCODE);
        result_valid = (state == DONE);
        norm_load    = gate_end;
        norm_step    = (state == ENCODE);
    end

    // Gate and wrap counters; overflow flags a wrap lost to saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt <= '0;
            wrap_cnt <= '0;
            prev_msb <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            gate_cnt <= '0;
            wrap_cnt <= '0;
            prev_msb <= sample_in[7];
            overflow <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            wrap_cnt <= wrap_cnt_next;
            prev_msb <= sample_in[7];
            if (wrap && wrap_sat) overflow <= 1'b1;
        end
    end

    // Result register; holds the last word until the next normalisation completes.
    always_ff @(posedge clk) begin
        if (reset)                               freq_word <= 16'h0000;
        else if ((state == ENCODE) && norm_done) freq_word <= norm_word;
    end

    tone_freq_normaliser u_normaliser (
        .clk      (clk),
        .reset    (reset),
        .load     (norm_load),
        .load_val (norm_val),
        .step     (norm_step),
        .done     (norm_done),
        .word     (norm_word)
    );

endmodule

// File: tb/tb_tone_freq_meter.sv
// Self-checking bench for tone_freq_meter with GATE_LOG2=12, driven by a
// phase-accumulator generator model reset together with the meter.
module tb_tone_freq_meter;

    localparam int G       = 12;
    localparam int TIMEOUT = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sample_in;
    logic        start;
    logic        busy;
    logic        result_valid;
    logic [15:0] freq_word;
    logic        overflow;

    logic [23:0] acc;
    logic [23:0] incr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] gen_word;
        logic [15:0] exp_fw;
        int          exp_lat;
    } vec_t;

    vec_t vecs [3];

    always #5 clk = ~clk;

    tone_freq_meter #(.GATE_LOG2(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .start        (start),
        .busy         (busy),
        .result_valid (result_valid),
        .freq_word    (freq_word),
        .overflow     (overflow)
    );

    // Generator model: accumulator steps by the decoded increment every cycle.
    always @(posedge clk) begin
        if (reset) acc <= '0;
        else       acc <= acc + incr;
    end
    assign sample_in = acc[23:16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_word(input logic [15:0] w);
        logic [3:0]  e;
        logic [23:0] m;
        m    = {12'h000, w[15:4]};
        e    = w[3:0];
        if (e > 4'd12) e = 4'd12;
        incr = m << e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start, then count cycles until result_valid rises. Optionally keep start
    // high throughout, or re-pulse it for one cycle at cycle pulse_at while busy.
    task automatic measure(input logic hold, input int pulse_at, output int lat);
        start = 1'b1;
        tick();
        lat = 1;
        if (!hold) start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_rv_clear", result_valid, 0);
        while (!result_valid && lat < TIMEOUT) begin
            if (pulse_at > 0) start = (lat == pulse_at);
            tick();
            lat++;
            if (pulse_at > 0 && lat == pulse_at + 1) check("mid_gate_busy", busy, 1);
        end
        start = hold;
        if (lat >= TIMEOUT) check("timeout", 0, 1);
    endtask

    initial begin
        int lat;

        vecs[0] = '{gen_word: 16'h001C, exp_fw: 16'h8001, exp_lat: 4099};
        vecs[1] = '{gen_word: 16'h040C, exp_fw: 16'h8007, exp_lat: 4105};
        vecs[2] = '{gen_word: 16'h0000, exp_fw: 16'h0000, exp_lat: 4098};

        reset = 1'b1;
        start = 1'b0;
        set_word(16'h0000);
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_rv", result_valid, 0);
        check("reset_fw", freq_word, 16'h0000);
        check("reset_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // Table-driven measurements.
        for (int i = 0; i < 3; i++) begin
            set_word(vecs[i].gen_word);
            measure(1'b0, 0, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_fw", i), freq_word, vecs[i].exp_fw);
            check($sformatf("v%0d_ovf", i), overflow, 0);
            check($sformatf("v%0d_busy", i), busy, 0);
            tick();
            check($sformatf("v%0d_rv_level", i), result_valid, 1);
        end

        // Start pulsed mid-gate is ignored: same latency, single result.
        set_word(16'h001C);
        measure(1'b0, 1000, lat);
        check("ignore_latency", lat, 4099);
        check("ignore_fw", freq_word, 16'h8001);

        // Reset mid-gate aborts with no result and clears the held word.
        measure_abort: begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (500) tick();
            check("abort_busy_before", busy, 1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_rv", result_valid, 0);
            check("abort_fw", freq_word, 16'h0000);
            repeat (4200) tick();
            check("abort_no_result", result_valid, 0);
        end

        // start held high in DONE re-arms; result_valid pulses one cycle per result.
        set_word(16'h020C);
        measure(1'b1, 0, lat);
        check("b2b_lat0", lat, 4104);
        check("b2b_fw0", freq_word, 16'h8006);
        tick();
        check("b2b_rv_pulse", result_valid, 0);
        check("b2b_rearm_busy", busy, 1);
        lat = 1;
        while (!result_valid && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        check("b2b_lat1", lat, 4104);
        check("b2b_fw1", freq_word, 16'h8006);
        start = 1'b0;
        tick();
        check("b2b_rv_hold", result_valid, 1);
        check("b2b_fw_hold", freq_word, 16'h8006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
